// File: rtl/dcache_mshr_alloc_arbiter.sv
// MSHR allocator: round-robin grant of one new entry per cycle, plus busy/address tracking and release.
// Latency: ack/id/merged are combinational; busy, addresses, full and busyCount follow one edge later.
// Backpressure: a request that is not acked (lost RR, table full, or stalled on a match) must hold until acked.
// Optional same-cycle merge onto a busy entry: define RSD_DCACHE_MSHR_MERGE_EN.
module dcache_mshr_alloc_arbiter #(
    parameter int MSHR_NUM        = 2,
    parameter int LINE_ADDR_WIDTH = 29,
    parameter int REQ_NUM         = 2,
    localparam int ID_W  = (MSHR_NUM > 1) ? $clog2(MSHR_NUM) : 1,
    localparam int RR_W  = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1,
    localparam int CNT_W = $clog2(MSHR_NUM) + 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [REQ_NUM-1:0]                  reqValid,
    input  logic [REQ_NUM*LINE_ADDR_WIDTH-1:0]  reqLineAddr,
    output logic [REQ_NUM-1:0]                  reqAck,
    output logic [REQ_NUM*ID_W-1:0]             reqMshrId,
    output logic [REQ_NUM-1:0]                  reqMerged,
    input  logic                                freeValid,
    input  logic [ID_W-1:0]                     freeId,
    output logic [MSHR_NUM-1:0]                 mshrBusy,
    output logic [MSHR_NUM*LINE_ADDR_WIDTH-1:0] mshrLineAddr,
    output logic                                full,
    output logic [CNT_W-1:0]                    busyCount,
    output logic                                errFree
);

    logic [MSHR_NUM-1:0]        busy_q;
    logic [LINE_ADDR_WIDTH-1:0] addr_q [MSHR_NUM];
    logic [RR_W-1:0]            rr_q;
    logic                       err_q;

    logic [MSHR_NUM-1:0]        rel_vec;
    logic [REQ_NUM-1:0]         any_match;
    logic [REQ_NUM-1:0]         cand;
    logic [ID_W-1:0]            free_id;
    logic                       has_free;
    logic                       win_found;
    int                         win_idx;
    logic                       alloc;
    logic [LINE_ADDR_WIDTH-1:0] win_addr;
    logic [RR_W-1:0]            next_rr;

    // An entry being released this cycle no longer counts as a match target.
    always_comb begin
        rel_vec = '0;
        for (int e = 0; e < MSHR_NUM; e++) begin
            rel_vec[e] = freeValid && (freeId == ID_W'(e));
        end
    end

    always_comb begin
        any_match = '0;
        for (int r = 0; r < REQ_NUM; r++) begin
            for (int e = 0; e < MSHR_NUM; e++) begin
                if (busy_q[e] && !rel_vec[e] &&
                    addr_q[e] == reqLineAddr[r*LINE_ADDR_WIDTH +: LINE_ADDR_WIDTH]) begin
                    any_match[r] = 1'b1;
                end
            end
        end
        cand = reqValid & ~any_match;
    end

`ifdef RSD_DCACHE_MSHR_MERGE_EN
    logic [ID_W-1:0] match_id [REQ_NUM];

    always_comb begin
        for (int r = 0; r < REQ_NUM; r++) begin
            match_id[r] = '0;
            for (int e = MSHR_NUM - 1; e >= 0; e--) begin
                if (busy_q[e] && !rel_vec[e] &&
                    addr_q[e] == reqLineAddr[r*LINE_ADDR_WIDTH +: LINE_ADDR_WIDTH]) begin
                    match_id[r] = ID_W'(e);
                end
            end
        end
    end
`endif

    // Freed entries only become allocatable next cycle, so use registered busy.
    always_comb begin
        free_id  = '0;
        has_free = ~(&busy_q);
        for (int e = MSHR_NUM - 1; e >= 0; e--) begin
            if (!busy_q[e]) free_id = ID_W'(e);
        end
    end

    always_comb begin
        win_found = 1'b0;
        win_idx   = 0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (!win_found && cand[(int'(rr_q) + i) % REQ_NUM]) begin
                win_found = 1'b1;
                win_idx   = (int'(rr_q) + i) % REQ_NUM;
            end
        end
        alloc    = rst_n && win_found && has_free;
        win_addr = reqLineAddr[win_idx*LINE_ADDR_WIDTH +: LINE_ADDR_WIDTH];
        next_rr  = RR_W'((win_idx + 1) % REQ_NUM);
    end

    always_comb begin
        reqAck    = '0;
        reqMshrId = '0;
        reqMerged = '0;
        for (int r = 0; r < REQ_NUM; r++) begin
            if (alloc && win_idx == r) begin
                reqAck[r]                = 1'b1;
                reqMshrId[r*ID_W +: ID_W] = free_id;
            end
`ifdef RSD_DCACHE_MSHR_MERGE_EN
            else if (rst_n && reqValid[r] && any_match[r]) begin
                reqAck[r]                = 1'b1;
                reqMshrId[r*ID_W +: ID_W] = match_id[r];
                reqMerged[r]             = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            rr_q   <= '0;
            err_q  <= 1'b0;
            for (int e = 0; e < MSHR_NUM; e++) begin
                addr_q[e] <= '0;
            end
        end else begin
            for (int e = 0; e < MSHR_NUM; e++) begin
                if (alloc && free_id == ID_W'(e)) begin
                    busy_q[e] <= 1'b1;
                    addr_q[e] <= win_addr;
                end else if (rel_vec[e]) begin
                    busy_q[e] <= 1'b0;
                end
            end
            if (freeValid && (rel_vec & busy_q) == '0) begin
                err_q <= 1'b1;
            end
            if (alloc) begin
                rr_q <= next_rr;
            end
        end
    end

    always_comb begin
        busyCount = '0;
        for (int e = 0; e < MSHR_NUM; e++) begin
            busyCount = busyCount + CNT_W'(busy_q[e]);
        end
    end

    for (genvar e = 0; e < MSHR_NUM; e++) begin : g_addr_out
        assign mshrLineAddr[e*LINE_ADDR_WIDTH +: LINE_ADDR_WIDTH] = addr_q[e];
    end

    assign mshrBusy = busy_q;
    assign full     = &busy_q;
    assign errFree  = err_q;

endmodule

// File: tb/tb_dcache_mshr_alloc_arbiter.sv
// Directed table-driven bench for dcache_mshr_alloc_arbiter (2 entries, 2 requesters), plus reset sequences.
module tb_dcache_mshr_alloc_arbiter;

`ifdef RSD_DCACHE_MSHR_MERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  reqValid;
    logic [57:0] reqLineAddr;
    logic [1:0]  reqAck;
    logic [1:0]  reqMshrId;
    logic [1:0]  reqMerged;
    logic        freeValid;
    logic        freeId;
    logic [1:0]  mshrBusy;
    logic [57:0] mshrLineAddr;
    logic        full;
    logic [1:0]  busyCount;
    logic        errFree;

    int checks   = 0;
    int failures = 0;

    dcache_mshr_alloc_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .reqValid(reqValid), .reqLineAddr(reqLineAddr),
        .reqAck(reqAck), .reqMshrId(reqMshrId), .reqMerged(reqMerged),
        .freeValid(freeValid), .freeId(freeId),
        .mshrBusy(mshrBusy), .mshrLineAddr(mshrLineAddr),
        .full(full), .busyCount(busyCount), .errFree(errFree)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  v;
        logic [28:0] a0, a1;
        logic        fv, fid;
        logic [1:0]  ack;
        logic        id0, id1;
        logic [1:0]  mrg;
        logic [1:0]  busy;
        logic [1:0]  cnt;
        logic        full;
        logic        err;
        logic        ca;
        logic [28:0] ea0, ea1;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(logic [1:0] v, logic [28:0] a0, logic [28:0] a1, logic fv, logic fid,
                                logic [1:0] ack, logic id0, logic id1, logic [1:0] mrg,
                                logic [1:0] busy, logic [1:0] cnt, logic f, logic err,
                                logic ca, logic [28:0] ea0, logic [28:0] ea1);
        vec_t t;
        t.v = v; t.a0 = a0; t.a1 = a1; t.fv = fv; t.fid = fid;
        t.ack = ack; t.id0 = id0; t.id1 = id1; t.mrg = mrg;
        t.busy = busy; t.cnt = cnt; t.full = f; t.err = err;
        t.ca = ca; t.ea0 = ea0; t.ea1 = ea1;
        return t;
    endfunction

    task automatic chk(input string name, input int row, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%0h want=%0h", name, row, got, exp);
        end
    endtask

    task automatic check_reset_state(input int row);
        chk("rst_ack", row, 64'(reqAck), 64'd0);
        chk("rst_busy", row, 64'(mshrBusy), 64'd0);
        chk("rst_cnt", row, 64'(busyCount), 64'd0);
        chk("rst_full", row, 64'(full), 64'd0);
        chk("rst_err", row, 64'(errFree), 64'd0);
        chk("rst_addr", row, 64'(mshrLineAddr), 64'd0);
    endtask

    initial begin
        tbl[0]  = mk(2'b01, 29'h100, 29'h0,   1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0, 29'h0,   29'h0);
        tbl[1]  = mk(2'b00, 29'h0,   29'h0,   1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b01, 2'd1, 1'b0, 1'b0, 1'b1, 29'h100, 29'h0);
        tbl[2]  = mk(2'b10, 29'h0,   29'h500, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 2'b00, 2'b01, 2'd1, 1'b0, 1'b0, 1'b0, 29'h0,   29'h0);
        tbl[3]  = mk(2'b00, 29'h0,   29'h0,   1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b10, 2'd1, 1'b0, 1'b0, 1'b1, 29'h100, 29'h500);
        tbl[4]  = mk(2'b11, 29'h200, 29'h300, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0, 29'h0,   29'h0);
        tbl[5]  = mk(2'b11, 29'h200, 29'h300, 1'b0, 1'b0, MERGE ? 2'b11 : 2'b10, 1'b0, 1'b1,
                     MERGE ? 2'b01 : 2'b00, 2'b01, 2'd1, 1'b0, 1'b0, 1'b1, 29'h200, 29'h500);
        tbl[6]  = mk(2'b00, 29'h0,   29'h0,   1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b11, 2'd2, 1'b1, 1'b0, 1'b1, 29'h200, 29'h300);
        tbl[7]  = mk(2'b01, 29'h400, 29'h0,   1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b11, 2'd2, 1'b1, 1'b0, 1'b0, 29'h0,   29'h0);
        tbl[8]  = mk(2'b01, 29'h400, 29'h0,   1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 2'b00, 2'b01, 2'd1, 1'b0, 1'b0, 1'b0, 29'h0,   29'h0);
        tbl[9]  = mk(2'b10, 29'h0,   29'h200, 1'b0, 1'b0, MERGE ? 2'b10 : 2'b00, 1'b0, 1'b0,
                     MERGE ? 2'b10 : 2'b00, 2'b11, 2'd2, 1'b1, 1'b0, 1'b1, 29'h200, 29'h400);
        tbl[10] = mk(2'b10, 29'h0,   29'h200, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b11, 2'd2, 1'b1, 1'b0, 1'b0, 29'h0,   29'h0);
        tbl[11] = mk(2'b10, 29'h0,   29'h200, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 2'b10, 2'd1, 1'b0, 1'b0, 1'b0, 29'h0,   29'h0);
        tbl[12] = mk(2'b00, 29'h0,   29'h0,   1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b11, 2'd2, 1'b1, 1'b0, 1'b1, 29'h200, 29'h400);
        tbl[13] = mk(2'b00, 29'h0,   29'h0,   1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b01, 2'd1, 1'b0, 1'b0, 1'b0, 29'h0,   29'h0);
        tbl[14] = mk(2'b00, 29'h0,   29'h0,   1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b01, 2'd1, 1'b0, 1'b1, 1'b1, 29'h200, 29'h400);
        tbl[15] = mk(2'b11, 29'h600, 29'h600, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 2'b00, 2'b01, 2'd1, 1'b0, 1'b1, 1'b0, 29'h0,   29'h0);
        tbl[16] = mk(2'b11, 29'h600, 29'h600, 1'b0, 1'b0, MERGE ? 2'b11 : 2'b00, 1'b1, 1'b1,
                     MERGE ? 2'b11 : 2'b00, 2'b11, 2'd2, 1'b1, 1'b1, 1'b1, 29'h200, 29'h600);

        rst_n       = 1'b0;
        reqValid    = 2'b11;
        reqLineAddr = {29'h300, 29'h200};
        freeValid   = 1'b0;
        freeId      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state(-1);
        reqValid = 2'b00;
        rst_n    = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(posedge clk);
            #1;
            reqValid    = tbl[i].v;
            reqLineAddr = {tbl[i].a1, tbl[i].a0};
            freeValid   = tbl[i].fv;
            freeId      = tbl[i].fid;
            @(negedge clk);
            chk("ack", i, 64'(reqAck), 64'(tbl[i].ack));
            if (tbl[i].ack[0]) chk("id0", i, 64'(reqMshrId[0]), 64'(tbl[i].id0));
            if (tbl[i].ack[1]) chk("id1", i, 64'(reqMshrId[1]), 64'(tbl[i].id1));
            chk("merged", i, 64'(reqMerged & reqAck), 64'(tbl[i].mrg));
            chk("busy", i, 64'(mshrBusy), 64'(tbl[i].busy));
            chk("count", i, 64'(busyCount), 64'(tbl[i].cnt));
            chk("full", i, 64'(full), 64'(tbl[i].full));
            chk("errfree", i, 64'(errFree), 64'(tbl[i].err));
            if (tbl[i].ca) begin
                chk("addr0", i, 64'(mshrLineAddr[28:0]), 64'(tbl[i].ea0));
                chk("addr1", i, 64'(mshrLineAddr[57:29]), 64'(tbl[i].ea1));
            end
        end

        // Mid-operation reset: state must clear without waiting for an edge.
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state(100);

        // After reset the RR pointer is back at requester 0.
        @(negedge clk);
        rst_n       = 1'b1;
        reqValid    = 2'b11;
        reqLineAddr = {29'h800, 29'h700};
        #1;
        chk("post_rst_ack", 101, 64'(reqAck), 64'b01);
        chk("post_rst_id0", 101, 64'(reqMshrId[0]), 64'd0);
        @(posedge clk);
        #1;
        reqValid = 2'b00;
        @(negedge clk);
        chk("post_rst_busy", 102, 64'(mshrBusy), 64'b01);
        chk("post_rst_addr0", 102, 64'(mshrLineAddr[28:0]), 64'h700);
        chk("post_rst_cnt", 102, 64'(busyCount), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
